// File: rtl/game_sequencer_if.sv
// ----------------------------------------------------------------------------
// game_sequencer_if
// Bundles the sequencer <-> datapath/top-level handshake signals.
//   master : the sequencer (consumes done flags, start, link_hp; drives the
//            phase enables, game_over, frame_count, wdog_fault)
//   slave  : the datapath / top level (the opposite directions)
// Signals:
//   start, link_hp[2:0]                       restart request, Link HP
//   idle_done .. draw_vga_done                 datapath done flags (level)
//   init .. draw_to_vga                        one-hot phase enables
//   game_over, frame_count[15:0], wdog_fault   status
// ----------------------------------------------------------------------------
interface game_sequencer_if;
  logic        start;
  logic [2:0]  link_hp;
  logic        idle_done;
  logic        gen_move_done;
  logic        check_collide_done;
  logic        draw_map_done;
  logic        draw_link_done;
  logic        draw_enemies_done;
  logic        draw_vga_done;
  logic        init;
  logic        idle;
  logic        gen_move;
  logic        check_collide;
  logic        apply_act_link;
  logic        move_enemies;
  logic        draw_map;
  logic        draw_link;
  logic        draw_enemies;
  logic        draw_to_vga;
  logic        game_over;
  logic [15:0] frame_count;
  logic        wdog_fault;

  modport master (
    input  start, link_hp, idle_done, gen_move_done, check_collide_done,
           draw_map_done, draw_link_done, draw_enemies_done, draw_vga_done,
    output init, idle, gen_move, check_collide, apply_act_link, move_enemies,
           draw_map, draw_link, draw_enemies, draw_to_vga, game_over,
           frame_count, wdog_fault
  );

  modport slave (
    output start, link_hp, idle_done, gen_move_done, check_collide_done,
           draw_map_done, draw_link_done, draw_enemies_done, draw_vga_done,
    input  init, idle, gen_move, check_collide, apply_act_link, move_enemies,
           draw_map, draw_link, draw_enemies, draw_to_vga, game_over,
           frame_count, wdog_fault
  );
endinterface

// File: rtl/game_sequencer.sv
// ----------------------------------------------------------------------------
// game_sequencer
// Frame scheduler for the game datapath: INIT once, then per frame IDLE,
// GEN_MOVE, CHECK_COLLIDE, APPLY_LINK, MOVE_ENEMIES, DRAW_MAP, DRAW_LINK,
// DRAW_ENEMIES, DRAW_VGA; GAME_OVER when Link's HP is 0 at frame end.
// Ports:
//   clock  system clock (single domain)
//   reset  synchronous, active-high
//   bus    game_sequencer_if.master (done flags in, phase enables out)
// Optional feature: define SEQ_WATCHDOG_EN to add a per-wait-state watchdog
// that forces the state to advance after WDOG_LIMIT cycles and sets a sticky
// wdog_fault. Without it, wait states wait forever and wdog_fault is 0.
// All outputs are registered decodes of the next state.
// ----------------------------------------------------------------------------
module game_sequencer #(
  parameter logic [3:0]        INIT_CYCLES = 4'd2,
  parameter int                WDOG_W      = 24,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT  = 24'd2_000_000
) (
  input logic              clock,
  input logic              reset,
  game_sequencer_if.master bus
);

  // State encoding doubles as the bit position of the matching output.
  localparam logic [3:0] S_INIT          = 4'd0;
  localparam logic [3:0] S_IDLE          = 4'd1;
  localparam logic [3:0] S_GEN_MOVE      = 4'd2;
  localparam logic [3:0] S_CHECK_COLLIDE = 4'd3;
  localparam logic [3:0] S_APPLY_LINK    = 4'd4;
  localparam logic [3:0] S_MOVE_ENEMIES  = 4'd5;
  localparam logic [3:0] S_DRAW_MAP      = 4'd6;
  localparam logic [3:0] S_DRAW_LINK     = 4'd7;
  localparam logic [3:0] S_DRAW_ENEMIES  = 4'd8;
  localparam logic [3:0] S_DRAW_VGA      = 4'd9;
  localparam logic [3:0] S_GAME_OVER     = 4'd10;

  logic [3:0]  state_r;
  logic [3:0]  state_nxt_s;
  logic [3:0]  init_cnt_r;
  logic        guard_r;      // first cycle of a state: done flags are stale
  logic        wait_s;
  logic        done_sel_s;
  logic        adv_s;
  logic        wdog_hit_s;
  logic [10:0] en_nxt_s;
  logic [10:0] en_r;
  logic [15:0] frame_count_r;

  // Select the done flag belonging to the current wait state.
  always_comb begin
    wait_s     = 1'b1;
    done_sel_s = 1'b0;
    case (state_r)
      S_IDLE:          done_sel_s = bus.idle_done;
      S_GEN_MOVE:      done_sel_s = bus.gen_move_done;
      S_CHECK_COLLIDE: done_sel_s = bus.check_collide_done;
      S_DRAW_MAP:      done_sel_s = bus.draw_map_done;
      S_DRAW_LINK:     done_sel_s = bus.draw_link_done;
      S_DRAW_ENEMIES:  done_sel_s = bus.draw_enemies_done;
      S_DRAW_VGA:      done_sel_s = bus.draw_vga_done;
      default:         wait_s     = 1'b0;
    endcase
  end

  assign adv_s = wait_s & ((~guard_r & done_sel_s) | wdog_hit_s);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_INIT: begin
        // init_cnt_r counts cycles already shown with init high
        if (init_cnt_r >= INIT_CYCLES) state_nxt_s = S_IDLE;
        else                           state_nxt_s = S_INIT;
      end
      S_IDLE: begin
        if (adv_s) state_nxt_s = S_GEN_MOVE;
        else       state_nxt_s = S_IDLE;
      end
      S_GEN_MOVE: begin
        if (adv_s) state_nxt_s = S_CHECK_COLLIDE;
        else       state_nxt_s = S_GEN_MOVE;
      end
      S_CHECK_COLLIDE: begin
        if (adv_s) state_nxt_s = S_APPLY_LINK;
        else       state_nxt_s = S_CHECK_COLLIDE;
      end
      S_APPLY_LINK:   state_nxt_s = S_MOVE_ENEMIES;
      S_MOVE_ENEMIES: state_nxt_s = S_DRAW_MAP;
      S_DRAW_MAP: begin
        if (adv_s) state_nxt_s = S_DRAW_LINK;
        else       state_nxt_s = S_DRAW_MAP;
      end
      S_DRAW_LINK: begin
        if (adv_s) state_nxt_s = S_DRAW_ENEMIES;
        else       state_nxt_s = S_DRAW_LINK;
      end
      S_DRAW_ENEMIES: begin
        if (adv_s) state_nxt_s = S_DRAW_VGA;
        else       state_nxt_s = S_DRAW_ENEMIES;
      end
      S_DRAW_VGA: begin
        if (adv_s && (bus.link_hp == 3'd0)) state_nxt_s = S_GAME_OVER;
        else if (adv_s)                     state_nxt_s = S_IDLE;
        else                                state_nxt_s = S_DRAW_VGA;
      end
      S_GAME_OVER: begin
        if (bus.start) state_nxt_s = S_INIT;
        else           state_nxt_s = S_GAME_OVER;
      end
      default: state_nxt_s = S_INIT;
    endcase
  end

  // One-hot decode of the next state; bit 10 is game_over.
  always_comb begin
    en_nxt_s = 11'(11'd1 << state_nxt_s);
  end

  // State, INIT counter, guard, frame counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= S_INIT;
      init_cnt_r    <= 4'd0;
      guard_r       <= 1'b1;
      en_r          <= 11'd0;
      frame_count_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      guard_r <= (state_nxt_s != state_r);
      en_r    <= en_nxt_s;
      // Entering INIT from GAME_OVER already shows one init cycle.
      if (state_nxt_s != S_INIT)   init_cnt_r <= 4'd0;
      else if (state_r == S_INIT)  init_cnt_r <= init_cnt_r + 4'd1;
      else                         init_cnt_r <= 4'd1;
      if (state_r == S_GAME_OVER && state_nxt_s == S_INIT)
        frame_count_r <= 16'd0;
      else if (state_r == S_DRAW_VGA && adv_s)
        frame_count_r <= frame_count_r + 16'd1;
      else
        frame_count_r <= frame_count_r;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              wdog_fault_r;

  // Timeout fires on the cycle the count would reach WDOG_LIMIT.
  assign wdog_hit_s = wait_s &&
                      (wdog_cnt_r == (WDOG_LIMIT - {{(WDOG_W-1){1'b0}}, 1'b1}));

  // Watchdog counter (cleared on state entry) and sticky fault flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_cnt_r   <= {WDOG_W{1'b0}};
      wdog_fault_r <= 1'b0;
    end else begin
      if (state_nxt_s != state_r) wdog_cnt_r <= {WDOG_W{1'b0}};
      else if (wait_s)            wdog_cnt_r <= wdog_cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
      else                        wdog_cnt_r <= wdog_cnt_r;
      if (wdog_hit_s) wdog_fault_r <= 1'b1;
      else            wdog_fault_r <= wdog_fault_r;
    end
  end

  assign bus.wdog_fault = wdog_fault_r;
`else
  logic unused_wdog_s;
  assign unused_wdog_s  = ^WDOG_LIMIT;
  assign wdog_hit_s     = 1'b0;
  assign bus.wdog_fault = 1'b0;
`endif

  assign bus.init           = en_r[0];
  assign bus.idle           = en_r[1];
  assign bus.gen_move       = en_r[2];
  assign bus.check_collide  = en_r[3];
  assign bus.apply_act_link = en_r[4];
  assign bus.move_enemies   = en_r[5];
  assign bus.draw_map       = en_r[6];
  assign bus.draw_link      = en_r[7];
  assign bus.draw_enemies   = en_r[8];
  assign bus.draw_to_vga    = en_r[9];
  assign bus.game_over      = en_r[10];
  assign bus.frame_count    = frame_count_r;

endmodule

// File: tb/tb_game_sequencer.sv
// ----------------------------------------------------------------------------
// tb_game_sequencer
// Table-driven bench for game_sequencer: each row drives inputs for one cycle
// and lists the outputs expected after the following rising edge. Hand-written
// sequences cover the indefinite hold, mid-frame reset and (when the
// watchdog macro SEQ_WATCHDOG_EN is defined) the watchdog timeout.
// ----------------------------------------------------------------------------
module tb_game_sequencer;

  logic clock;
  logic reset;

  game_sequencer_if bus ();

  game_sequencer #(
    .INIT_CYCLES (4'd2),
    .WDOG_W      (24),
    .WDOG_LIMIT  (24'd10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output one-hot codes: {game_over, draw_to_vga, ..., idle, init}
  localparam logic [10:0] O_NONE  = 11'h000;
  localparam logic [10:0] O_INIT  = 11'h001;
  localparam logic [10:0] O_IDLE  = 11'h002;
  localparam logic [10:0] O_GEN   = 11'h004;
  localparam logic [10:0] O_COLL  = 11'h008;
  localparam logic [10:0] O_APPLY = 11'h010;
  localparam logic [10:0] O_MOVE  = 11'h020;
  localparam logic [10:0] O_MAP   = 11'h040;
  localparam logic [10:0] O_LINK  = 11'h080;
  localparam logic [10:0] O_ENEM  = 11'h100;
  localparam logic [10:0] O_VGA   = 11'h200;
  localparam logic [10:0] O_GO    = 11'h400;

  // Done flags: {vga, enemies, link, map, collide, move, idle}
  localparam logic [6:0] D_NONE = 7'h00;
  localparam logic [6:0] D_IDLE = 7'h01;
  localparam logic [6:0] D_MOVE = 7'h02;
  localparam logic [6:0] D_COLL = 7'h04;
  localparam logic [6:0] D_MAP  = 7'h08;
  localparam logic [6:0] D_LINK = 7'h10;
  localparam logic [6:0] D_ENEM = 7'h20;
  localparam logic [6:0] D_VGA  = 7'h40;

  typedef struct {
    logic        rst;
    logic        start;
    logic [2:0]  hp;
    logic [6:0]  done;
    logic [10:0] exp_out;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_err;

  function automatic logic [10:0] get_out();
    return {bus.game_over, bus.draw_to_vga, bus.draw_enemies, bus.draw_link,
            bus.draw_map, bus.move_enemies, bus.apply_act_link,
            bus.check_collide, bus.gen_move, bus.idle, bus.init};
  endfunction

  task automatic add(input logic r, input logic st, input logic [2:0] hp,
                     input logic [6:0] d, input logic [10:0] eo,
                     input logic [15:0] efc);
    vec_t v;
    v.rst = r; v.start = st; v.hp = hp; v.done = d;
    v.exp_out = eo; v.exp_fc = efc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic st, input logic [2:0] hp,
                       input logic [6:0] d);
    reset                  = r;
    bus.start              = st;
    bus.link_hp            = hp;
    bus.idle_done          = d[0];
    bus.gen_move_done      = d[1];
    bus.check_collide_done = d[2];
    bus.draw_map_done      = d[3];
    bus.draw_link_done     = d[4];
    bus.draw_enemies_done  = d[5];
    bus.draw_vga_done      = d[6];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Idle one cycle past the guard, then present the done flag for one cycle.
  task automatic wait_state(input logic [6:0] d);
    drive(1'b0, 1'b0, 3'd3, D_NONE);
    step();
    drive(1'b0, 1'b0, 3'd3, d);
    step();
    drive(1'b0, 1'b0, 3'd3, D_NONE);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive(1'b1, 1'b0, 3'd3, D_NONE);

    // Reset held 3 cycles, then init x2 and idle.
    add(1'b1, 1'b0, 3'd3, D_NONE, O_NONE, 16'd0);
    add(1'b1, 1'b0, 3'd3, D_NONE, O_NONE, 16'd0);
    add(1'b1, 1'b0, 3'd3, D_NONE, O_NONE, 16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_INIT, 16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_INIT, 16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_IDLE, 16'd0);
    // Nominal frame, done on 2nd cycle of each wait state, start ignored.
    add(1'b0, 1'b0, 3'd3, D_NONE, O_IDLE,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_IDLE, O_GEN,   16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_GEN,   16'd0);
    add(1'b0, 1'b0, 3'd3, D_MOVE, O_COLL,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_COLL,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_COLL, O_APPLY, 16'd0);
    add(1'b0, 1'b1, 3'd3, D_NONE, O_MOVE,  16'd0);
    add(1'b0, 1'b1, 3'd3, D_NONE, O_MAP,   16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_MAP,   16'd0);
    add(1'b0, 1'b0, 3'd3, D_MAP,  O_LINK,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_LINK,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_LINK, O_ENEM,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_ENEM,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_ENEM, O_VGA,   16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_VGA,   16'd0);
    add(1'b0, 1'b0, 3'd3, D_VGA,  O_IDLE,  16'd1);
    // Frame 2: foreign dones ignored, stale draw_map_done, HP 0 at end.
    add(1'b0, 1'b0, 3'd3, D_NONE, O_IDLE,  16'd1);
    add(1'b0, 1'b0, 3'd3, D_IDLE, O_GEN,   16'd1);
    add(1'b0, 1'b0, 3'd3, 7'h7D,  O_GEN,   16'd1);
    add(1'b0, 1'b0, 3'd3, 7'h7D,  O_GEN,   16'd1);
    add(1'b0, 1'b0, 3'd3, D_MOVE, O_COLL,  16'd1);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_COLL,  16'd1);
    add(1'b0, 1'b0, 3'd3, D_COLL, O_APPLY, 16'd1);
    add(1'b0, 1'b0, 3'd3, D_MAP,  O_MOVE,  16'd1);
    add(1'b0, 1'b1, 3'd3, D_MAP,  O_MAP,   16'd1);
    add(1'b0, 1'b0, 3'd3, D_MAP,  O_MAP,   16'd1);
    add(1'b0, 1'b0, 3'd3, D_MAP,  O_LINK,  16'd1);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_LINK,  16'd1);
    add(1'b0, 1'b0, 3'd3, D_LINK, O_ENEM,  16'd1);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_ENEM,  16'd1);
    add(1'b0, 1'b0, 3'd3, D_ENEM, O_VGA,   16'd1);
    add(1'b0, 1'b0, 3'd0, D_NONE, O_VGA,   16'd1);
    add(1'b0, 1'b0, 3'd0, D_VGA,  O_GO,    16'd2);
    // Game over: dones ignored, start restarts through INIT.
    add(1'b0, 1'b0, 3'd0, D_NONE, O_GO,    16'd2);
    add(1'b0, 1'b0, 3'd3, 7'h7F,  O_GO,    16'd2);
    add(1'b0, 1'b1, 3'd3, D_NONE, O_INIT,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_INIT,  16'd0);
    add(1'b0, 1'b0, 3'd3, D_NONE, O_IDLE,  16'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].hp, vecs[i].done);
      step();
      check($sformatf("row%0d_out", i), {5'd0, get_out()}, {5'd0, vecs[i].exp_out});
      check($sformatf("row%0d_fc", i), bus.frame_count, vecs[i].exp_fc);
    end
    check("wdog_after_table", {15'd0, bus.wdog_fault}, 16'd0);

`ifndef SEQ_WATCHDOG_EN
    // No dones at all: IDLE holds indefinitely.
    drive(1'b0, 1'b0, 3'd3, D_NONE);
    for (int k = 0; k < 30; k++) begin
      step();
      check($sformatf("hold%0d", k), {5'd0, get_out()}, {5'd0, O_IDLE});
    end
    check("hold_wdog", {15'd0, bus.wdog_fault}, 16'd0);
`endif

    // Walk to DRAW_LINK, then reset mid-frame.
    wait_state(D_IDLE);
    wait_state(D_MOVE);
    wait_state(D_COLL);
    check("walk_apply", {5'd0, get_out()}, {5'd0, O_APPLY});
    step();
    step();
    wait_state(D_MAP);
    check("walk_link", {5'd0, get_out()}, {5'd0, O_LINK});
    drive(1'b1, 1'b0, 3'd3, D_NONE);
    step();
    check("midrst_out", {5'd0, get_out()}, {5'd0, O_NONE});
    check("midrst_fc", bus.frame_count, 16'd0);
    drive(1'b0, 1'b0, 3'd3, D_NONE);
    step();
    check("rel_init0", {5'd0, get_out()}, {5'd0, O_INIT});
    step();
    check("rel_init1", {5'd0, get_out()}, {5'd0, O_INIT});
    step();
    check("rel_idle", {5'd0, get_out()}, {5'd0, O_IDLE});

`ifdef SEQ_WATCHDOG_EN
    begin
      int n;
      wait_state(D_IDLE);
      check("wd_gen", {5'd0, get_out()}, {5'd0, O_GEN});
      n = 0;
      while (get_out() == O_GEN && n < 40) begin
        step();
        n++;
      end
      check("wd_gen_len", n[15:0], 16'd10);
      check("wd_coll", {5'd0, get_out()}, {5'd0, O_COLL});
      check("wd_fault", {15'd0, bus.wdog_fault}, 16'd1);
      wait_state(D_COLL);
      step();
      step();
      wait_state(D_MAP);
      wait_state(D_LINK);
      wait_state(D_ENEM);
      wait_state(D_VGA);
      check("wd_next_frame", {5'd0, get_out()}, {5'd0, O_IDLE});
      check("wd_sticky", {15'd0, bus.wdog_fault}, 16'd1);
      drive(1'b1, 1'b0, 3'd3, D_NONE);
      step();
      check("wd_rst_clear", {15'd0, bus.wdog_fault}, 16'd0);
      drive(1'b0, 1'b0, 3'd3, D_NONE);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
